memory: RTL and testbench

//  Memory-access pipeline stage, directly upstream of the writeback stage.

---
 rtl/memory.sv | 177 +++++++++++++++++
 tb/tb_memory.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory.sv
// Memory-access pipeline stage: issues req/ack data-memory transactions for loads
// and stores and registers results into the MEM/WB boundary.
module memory #(
    parameter int unsigned ADDR_SIZE      = 5,
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned DMEM_ADDR_SIZE = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [WORD_SIZE-1:0]      alu_data_i,
    input  logic [WORD_SIZE-1:0]      store_data_i,
    input  logic                      mem_read_i,
    input  logic                      mem_write_i,
    input  logic [ADDR_SIZE-1:0]      rd_addr_i,
    input  logic                      rd_write_i,
    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [DMEM_ADDR_SIZE-1:0] dmem_addr_o,
    output logic [WORD_SIZE-1:0]      dmem_wdata_o,
    input  logic                      dmem_ack_i,
    input  logic [WORD_SIZE-1:0]      dmem_rdata_i,
    output logic                      valid_o,
    output logic [WORD_SIZE-1:0]      alu_data_o,
    output logic [WORD_SIZE-1:0]      mem_data_o,
    output logic                      rd_data_sel_o,
    output logic [ADDR_SIZE-1:0]      rd_addr_o,
    output logic                      rd_write_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic                      ready_q, ready_d;
    logic                      req_q, req_d;
    logic                      we_q, we_d;
    logic [DMEM_ADDR_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0]      wdata_q, wdata_d;

    // Fields of the in-flight memory op, released to MEM/WB on ack.
    logic [WORD_SIZE-1:0]      pend_alu_q, pend_alu_d;
    logic [ADDR_SIZE-1:0]      pend_rd_addr_q, pend_rd_addr_d;
    logic                      pend_rd_write_q, pend_rd_write_d;
    logic                      pend_load_q, pend_load_d;

    logic                      valid_q, valid_d;
    logic [WORD_SIZE-1:0]      alu_data_q, alu_data_d;
    logic [WORD_SIZE-1:0]      mem_data_q, mem_data_d;
    logic                      sel_q, sel_d;
    logic [ADDR_SIZE-1:0]      rd_addr_q, rd_addr_d;
    logic                      rd_write_q, rd_write_d;

    logic                      accept;

    // Next-state and output computation.
    always_comb begin
        state_d         = state_q;
        ready_d         = ready_q;
        req_d           = req_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        pend_alu_d      = pend_alu_q;
        pend_rd_addr_d  = pend_rd_addr_q;
        pend_rd_write_d = pend_rd_write_q;
        pend_load_d     = pend_load_q;
        valid_d         = 1'b0;
        alu_data_d      = alu_data_q;
        mem_data_d      = mem_data_q;
        sel_d           = sel_q;
        rd_addr_d       = rd_addr_q;
        rd_write_d      = 1'b0;
        accept          = valid_i & ready_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (mem_read_i | mem_write_i) begin
                        state_d         = ACCESS;
                        ready_d         = 1'b0;
                        req_d           = 1'b1;
                        we_d            = mem_write_i;
                        addr_d          = alu_data_i[DMEM_ADDR_SIZE-1:0];
                        wdata_d         = store_data_i;
                        pend_alu_d      = alu_data_i;
                        pend_rd_addr_d  = rd_addr_i;
                        pend_rd_write_d = rd_write_i;
                        // A simultaneous read+write is resolved as a store.
                        pend_load_d     = mem_read_i & ~mem_write_i;
                    end else begin
                        valid_d    = 1'b1;
                        alu_data_d = alu_data_i;
                        rd_addr_d  = rd_addr_i;
                        rd_write_d = rd_write_i;
                        sel_d      = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack_i) begin
                    state_d    = IDLE;
                    ready_d    = 1'b1;
                    req_d      = 1'b0;
                    valid_d    = 1'b1;
                    alu_data_d = pend_alu_q;
                    rd_addr_d  = pend_rd_addr_q;
                    rd_write_d = pend_rd_write_q;
                    sel_d      = pend_load_q;
                    if (pend_load_q) begin
                        mem_data_d = dmem_rdata_i;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            ready_q         <= 1'b1;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            pend_alu_q      <= '0;
            pend_rd_addr_q  <= '0;
            pend_rd_write_q <= 1'b0;
            pend_load_q     <= 1'b0;
            valid_q         <= 1'b0;
            alu_data_q      <= '0;
            mem_data_q      <= '0;
            sel_q           <= 1'b0;
            rd_addr_q       <= '0;
            rd_write_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            ready_q         <= ready_d;
            req_q           <= req_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            pend_alu_q      <= pend_alu_d;
            pend_rd_addr_q  <= pend_rd_addr_d;
            pend_rd_write_q <= pend_rd_write_d;
            pend_load_q     <= pend_load_d;
            valid_q         <= valid_d;
            alu_data_q      <= alu_data_d;
            mem_data_q      <= mem_data_d;
            sel_q           <= sel_d;
            rd_addr_q       <= rd_addr_d;
            rd_write_q      <= rd_write_d;
        end
    end

    assign ready_o       = ready_q;
    assign dmem_req_o    = req_q;
    assign dmem_we_o     = we_q;
    assign dmem_addr_o   = addr_q;
    assign dmem_wdata_o  = wdata_q;
    assign valid_o       = valid_q;
    assign alu_data_o    = alu_data_q;
    assign mem_data_o    = mem_data_q;
    assign rd_data_sel_o = sel_q;
    assign rd_addr_o     = rd_addr_q;
    assign rd_write_o    = rd_write_q;

endmodule

// File: tb/tb_memory.sv
// Bench for the memory stage: directed scenarios plus randomized transactions
// checked against a transaction-level expectation of every output.
module tb_memory;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] alu_data_i;
    logic [31:0] store_data_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [4:0]  rd_addr_i;
    logic        rd_write_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [7:0]  dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        valid_o;
    logic [31:0] alu_data_o;
    logic [31:0] mem_data_o;
    logic        rd_data_sel_o;
    logic [4:0]  rd_addr_o;
    logic        rd_write_o;

    memory dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .alu_data_i(alu_data_i), .store_data_i(store_data_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .rd_addr_i(rd_addr_i), .rd_write_i(rd_write_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .valid_o(valid_o), .alu_data_o(alu_data_o), .mem_data_o(mem_data_o),
        .rd_data_sel_o(rd_data_sel_o), .rd_addr_o(rd_addr_o), .rd_write_o(rd_write_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Expected values of every DUT output.
    logic        e_ready, e_req, e_we, e_valid, e_sel, e_rd_write;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata, e_alu, e_mem;
    logic [4:0]  e_rd_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        chk({step, ":ready"},    32'(ready_o),       32'(e_ready));
        chk({step, ":req"},      32'(dmem_req_o),    32'(e_req));
        chk({step, ":valid"},    32'(valid_o),       32'(e_valid));
        chk({step, ":rd_write"}, 32'(rd_write_o),    32'(e_rd_write));
        chk({step, ":we"},       32'(dmem_we_o),     32'(e_we));
        chk({step, ":addr"},     32'(dmem_addr_o),   32'(e_addr));
        chk({step, ":wdata"},    dmem_wdata_o,       e_wdata);
        chk({step, ":alu"},      alu_data_o,         e_alu);
        chk({step, ":mem"},      mem_data_o,         e_mem);
        chk({step, ":sel"},      32'(rd_data_sel_o), 32'(e_sel));
        chk({step, ":rd_addr"},  32'(rd_addr_o),     32'(e_rd_addr));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i     = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        dmem_ack_i  = 1'b0;
        rd_write_i  = 1'b0;
    endtask

    task automatic expect_reset_state();
        e_ready = 1'b1; e_req = 1'b0; e_we = 1'b0; e_valid = 1'b0; e_sel = 1'b0;
        e_rd_write = 1'b0; e_addr = '0; e_wdata = '0; e_alu = '0; e_mem = '0;
        e_rd_addr = '0;
    endtask

    task automatic do_reset(input int cycles);
        idle_inputs();
        rst_i = 1'b1;
        repeat (cycles) tick();
        expect_reset_state();
        check_all("reset");
        rst_i = 1'b0;
    endtask

    // One idle cycle: valid_o drops, everything else holds.
    task automatic idle_cycle(input string step, input logic spurious_ack);
        idle_inputs();
        dmem_ack_i   = spurious_ack;
        dmem_rdata_i = $urandom;
        alu_data_i   = $urandom;
        tick();
        dmem_ack_i = 1'b0;
        e_valid    = 1'b0;
        e_rd_write = 1'b0;
        check_all(step);
    endtask

    // Present a non-memory op; it must appear on MEM/WB one cycle later.
    task automatic alu_op(input logic [31:0] a, input logic [4:0] rd, input logic wr);
        valid_i      = 1'b1;
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
        dmem_ack_i   = 1'b0;
        alu_data_i   = a;
        store_data_i = $urandom;
        rd_addr_i    = rd;
        rd_write_i   = wr;
        tick();
        e_valid    = 1'b1;
        e_alu      = a;
        e_rd_addr  = rd;
        e_rd_write = wr;
        e_sel      = 1'b0;
        check_all("alu_op");
    endtask

    // Junk on the execute side while a request is outstanding; must be ignored.
    task automatic junk_inputs();
        valid_i      = 1'($urandom);
        mem_read_i   = 1'($urandom);
        mem_write_i  = 1'($urandom);
        alu_data_i   = $urandom;
        store_data_i = $urandom;
        rd_addr_i    = 5'($urandom);
        rd_write_i   = 1'($urandom);
        dmem_rdata_i = $urandom;
    endtask

    // Full memory transaction: accept, `wait_cycles` request cycles without ack,
    // then an ack cycle; result registered on the following cycle.
    task automatic mem_op(input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                          input logic wr, input logic ld, input logic st,
                          input int wait_cycles, input logic [31:0] rdata);
        valid_i      = 1'b1;
        mem_read_i   = ld;
        mem_write_i  = st;
        dmem_ack_i   = 1'b0;
        alu_data_i   = a;
        store_data_i = sd;
        rd_addr_i    = rd;
        rd_write_i   = wr;
        tick();
        e_ready = 1'b0; e_req = 1'b1; e_we = st; e_addr = a[7:0]; e_wdata = sd;
        e_valid = 1'b0; e_rd_write = 1'b0;
        check_all("mem_req");
        for (int i = 0; i < wait_cycles; i++) begin
            junk_inputs();
            tick();
            check_all("mem_wait");
        end
        junk_inputs();
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdata;
        tick();
        dmem_ack_i = 1'b0;
        valid_i    = 1'b0;
        e_ready = 1'b1; e_req = 1'b0; e_valid = 1'b1;
        e_alu = a; e_rd_addr = rd; e_rd_write = wr;
        e_sel = ld & ~st;
        if (ld && !st) e_mem = rdata;
        check_all("mem_done");
    endtask

    initial begin
        rst_i        = 1'b1;
        alu_data_i   = '0;
        store_data_i = '0;
        rd_addr_i    = '0;
        dmem_rdata_i = '0;
        idle_inputs();

        // Reset then idle.
        do_reset(2);
        idle_cycle("post_reset", 1'b0);

        // Back-to-back non-memory ops.
        alu_op(32'h11, 5'd3, 1'b1);
        alu_op(32'h22, 5'd4, 1'b1);
        idle_cycle("after_alu", 1'b0);

        // Load with ack delay 3.
        mem_op(32'h0000_0040, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3, 32'hDEAD_BEEF);
        idle_cycle("after_load", 1'b0);

        // Store, ack in first request cycle.
        mem_op(32'h0000_0010, 32'hCAFE_F00D, 5'd2, 1'b0, 1'b0, 1'b1, 0, 32'h1234_5678);
        idle_cycle("after_store", 1'b0);

        // Read and write together resolve as a store.
        mem_op(32'h0000_0123, 32'h5555_AAAA, 5'd9, 1'b1, 1'b1, 1'b1, 1, 32'h7777_7777);
        idle_cycle("after_rw", 1'b0);

        // Reset mid-ACCESS, then a stale ack.
        valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
        alu_data_i = 32'h80; rd_addr_i = 5'd5; rd_write_i = 1'b1;
        tick();
        idle_inputs();
        tick();
        do_reset(1);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hBAD0_BAD0;
        tick();
        dmem_ack_i = 1'b0;
        check_all("stale_ack");
        idle_cycle("after_stale", 1'b0);

        // Spurious ack in IDLE.
        idle_cycle("spurious_ack", 1'b1);

        // Randomized transactions.
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                alu_op($urandom, 5'($urandom), 1'($urandom));
            end else begin
                mem_op($urandom, $urandom, 5'($urandom), 1'($urandom),
                       (kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
                       int'($urandom_range(0, 4)), $urandom);
            end
            if ($urandom_range(0, 2) == 0) idle_cycle("rand_idle", 1'($urandom));
        end
        idle_cycle("final", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
